demux_stream: RTL and testbench

//  1-to-2 routing demultiplexer with valid/ready handshakes; the write-side counterpart to the datapath 2:1 muxes.

---
 rtl/demux_stream_pkg.sv | 9 +
 rtl/demux_slot.sv | 49 ++++
 rtl/demux_stream.sv | 59 +++++
 tb/tb_demux_stream.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared occupancy encoding and default width for the stream demux
package demux_stream_pkg;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;
    localparam int DEMUX_BIT_WIDTH = 8;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: two-entry head/skid buffer for one demux destination
// ports: clk, rst_n (async, active-low), push/wr_data (enqueue), pop (dequeue head),
//        data_out/valid (head word), occ (current occupancy)
module demux_slot
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = DEMUX_BIT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output occ_t             occ
);
    occ_t             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
        end
    end

    // A push that coincides with a pop at ONE replaces the head directly;
    // at FULL the skid word slides forward on pop.
    always_comb begin
        occ_d  = occ_q == OCC_EMPTY ? (push ? OCC_ONE : OCC_EMPTY)
               : occ_q == OCC_ONE   ? (push && !pop ? OCC_FULL : (pop && !push ? OCC_EMPTY : OCC_ONE))
               :                      (pop ? OCC_ONE : OCC_FULL);
        head_d = (occ_q == OCC_EMPTY && push) || (occ_q == OCC_ONE && push && pop) ? wr_data
               : (occ_q == OCC_FULL && pop) ? skid_q : head_q;
        skid_d = (occ_q == OCC_ONE && push && !pop) ? wr_data : skid_q;
    end

    always_comb begin
        valid    = occ_q != OCC_EMPTY;
        data_out = head_q;
        occ      = occ_q;
    end
endmodule

// File: rtl/demux_stream.sv
// demux_stream: 1-to-2 valid/ready demux with a 2-entry buffer per destination
// ports: clk, rst_n (async, active-low); data_in/sel/in_valid/in_ready (input stream);
//        data_out_n/valid_n/ready_n (output stream n); cnt_0/cnt_1 saturating pop counters
//        present only when DEMUX_COUNT_EN is defined
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int DEMUX_BIT_WIDTH = demux_stream_pkg::DEMUX_BIT_WIDTH,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DEMUX_BIT_WIDTH-1:0] data_in,
    input  logic                       sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DEMUX_BIT_WIDTH-1:0] data_out_0,
    output logic                       valid_0,
    input  logic                       ready_0,
    output logic [DEMUX_BIT_WIDTH-1:0] data_out_1,
    output logic                       valid_1,
    input  logic                       ready_1
`ifdef DEMUX_COUNT_EN
   ,output logic [CNT_WIDTH-1:0]       cnt_0,
    output logic [CNT_WIDTH-1:0]       cnt_1
`endif
);
    occ_t occ_0, occ_1;
    logic push_0, push_1, pop_0, pop_1;

    // in_ready looks only at registered occupancy, never at ready_n
    assign in_ready = (sel ? occ_1 : occ_0) != OCC_FULL;
    assign push_0   = in_valid && in_ready && !sel;
    assign push_1   = in_valid && in_ready && sel;
    assign pop_0    = valid_0 && ready_0;
    assign pop_1    = valid_1 && ready_1;

    demux_slot #(.WIDTH(DEMUX_BIT_WIDTH)) u_slot_0 (
        .clk(clk), .rst_n(rst_n), .push(push_0), .wr_data(data_in), .pop(pop_0),
        .data_out(data_out_0), .valid(valid_0), .occ(occ_0)
    );

    demux_slot #(.WIDTH(DEMUX_BIT_WIDTH)) u_slot_1 (
        .clk(clk), .rst_n(rst_n), .push(push_1), .wr_data(data_in), .pop(pop_1),
        .data_out(data_out_1), .valid(valid_1), .occ(occ_1)
    );

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (pop_0 && !(&cnt_0)) cnt_0 <= cnt_0 + CNT_WIDTH'(1);
            if (pop_1 && !(&cnt_1)) cnt_1 <= cnt_1 + CNT_WIDTH'(1);
        end
    end
`endif
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed stimulus with a queue-based reference model for demux_stream
module tb_demux_stream;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_out_0, data_out_1;
    logic          valid_0, valid_1;
    logic          ready_0 = 1'b0;
    logic          ready_1 = 1'b0;
`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] cnt_0, cnt_1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    always #5 clk = ~clk;

    demux_stream #(.DEMUX_BIT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready),
        .data_out_0(data_out_0), .valid_0(valid_0), .ready_0(ready_0),
        .data_out_1(data_out_1), .valid_1(valid_1), .ready_1(ready_1)
`ifdef DEMUX_COUNT_EN
       ,.cnt_0(cnt_0), .cnt_1(cnt_1)
`endif
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: each port is a FIFO of at most two words.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            logic acc;
            acc = in_valid && ((sel ? q1.size() : q0.size()) < 2);
            if (q0.size() > 0 && ready_0) begin
                void'(q0.pop_front());
                if (m_cnt0 < (1 << CW) - 1) m_cnt0++;
            end
            if (q1.size() > 0 && ready_1) begin
                void'(q1.pop_front());
                if (m_cnt1 < (1 << CW) - 1) m_cnt1++;
            end
            if (acc && !sel) q0.push_back(data_in);
            if (acc && sel) q1.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        #1;
        check("model_valid_0", 32'(valid_0), 32'(q0.size() != 0));
        check("model_valid_1", 32'(valid_1), 32'(q1.size() != 0));
        check("model_in_ready", 32'(in_ready), 32'((sel ? q1.size() : q0.size()) < 2));
        if (q0.size() != 0) check("model_data_0", 32'(data_out_0), 32'(q0[0]));
        if (q1.size() != 0) check("model_data_1", 32'(data_out_1), 32'(q1[0]));
`ifdef DEMUX_COUNT_EN
        check("model_cnt_0", 32'(cnt_0), 32'(m_cnt0));
        check("model_cnt_1", 32'(cnt_1), 32'(m_cnt1));
`endif
    end

    task automatic step(input logic iv, input logic s, input logic [DW-1:0] d,
                        input logic r0, input logic r1);
        @(negedge clk);
        in_valid = iv;
        sel      = s;
        data_in  = d;
        ready_0  = r0;
        ready_1  = r1;
        #2;
    endtask

    initial begin
        #3;
        check("reset_valid_0", 32'(valid_0), 32'd0);
        check("reset_valid_1", 32'(valid_1), 32'd0);
        check("reset_data_0", 32'(data_out_0), 32'd0);
        check("reset_data_1", 32'(data_out_1), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single word to port 0
        step(1, 0, 8'hA5, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        check("t1_valid_0", 32'(valid_0), 32'd1);
        check("t1_data_0", 32'(data_out_0), 32'hA5);
        check("t1_valid_1", 32'(valid_1), 32'd0);

        // 2: port 1 stalled, port 0 still flows
        step(1, 1, 8'h11, 1, 0);
        step(1, 1, 8'h22, 1, 0);
        step(0, 1, 8'h00, 1, 0);
        check("t2_in_ready_sel1", 32'(in_ready), 32'd0);
        step(0, 0, 8'h00, 1, 0);
        check("t2_in_ready_sel0", 32'(in_ready), 32'd1);
        step(1, 0, 8'h33, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        check("t2_data_0", 32'(data_out_0), 32'h33);
        check("t2_head_1", 32'(data_out_1), 32'h11);
        step(0, 0, 8'h00, 1, 1);
        check("t2_first_1", 32'(data_out_1), 32'h11);
        step(0, 0, 8'h00, 1, 1);
        check("t2_second_1", 32'(data_out_1), 32'h22);
        step(0, 0, 8'h00, 1, 1);
        check("t2_drained_1", 32'(valid_1), 32'd0);

        // 3: back-to-back stream on port 0
        for (int i = 0; i < 16; i++) begin
            step(1, 0, DW'(i), 1, 0);
            check("t3_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) check("t3_stream_data", 32'(data_out_0), 32'(i - 1));
        end
        step(0, 0, 8'h00, 1, 0);
        check("t3_last_data", 32'(data_out_0), 32'h0F);
        step(0, 0, 8'h00, 1, 0);
        check("t3_drained", 32'(valid_0), 32'd0);

        // 4: push+pop at ONE, pop from FULL
        step(1, 0, 8'h40, 0, 0);
        step(1, 0, 8'h41, 1, 0);
        check("t4_one_head", 32'(data_out_0), 32'h40);
        step(1, 0, 8'h42, 0, 0);
        check("t4_swap_head", 32'(data_out_0), 32'h41);
        check("t4_swap_not_full", 32'(in_ready), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        check("t4_full_in_ready", 32'(in_ready), 32'd0);
        check("t4_full_head", 32'(data_out_0), 32'h41);
        step(0, 0, 8'h00, 0, 0);
        check("t4_skid_head", 32'(data_out_0), 32'h42);
        check("t4_skid_valid", 32'(valid_0), 32'd1);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        check("t4_empty", 32'(valid_0), 32'd0);

        // 5: async reset with both ports full
        step(1, 0, 8'h51, 0, 0);
        step(1, 0, 8'h52, 0, 0);
        step(1, 1, 8'h61, 0, 0);
        step(1, 1, 8'h62, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        check("t5_full_in_ready", 32'(in_ready), 32'd0);
        check("t5_full_valid_1", 32'(valid_1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid_0", 32'(valid_0), 32'd0);
        check("t5_rst_valid_1", 32'(valid_1), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check("t5_rst_data_0", 32'(data_out_0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6: 20 pops on port 1
        for (int i = 0; i < 20; i++) step(1, 1, DW'(8'h80 + i), 0, 1);
        step(0, 1, 8'h00, 0, 1);
        step(0, 1, 8'h00, 0, 1);
        check("t6_drained_1", 32'(valid_1), 32'd0);
`ifdef DEMUX_COUNT_EN
        check("t6_cnt_1_sat", 32'(cnt_1), 32'hF);
        check("t6_cnt_0", 32'(cnt_0), 32'd0);
`endif
        step(0, 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
